// File: rtl/svga_timing_pkg.sv
// Shared constants for the SVGA raster sequencer: the segment state encoding,
// the 800x600@60 default timing and the coordinate width.
package svga_timing_pkg;

    localparam int CW = 11;

    localparam logic [1:0] ST_SYNC   = 2'b00;
    localparam logic [1:0] ST_BP     = 2'b01;
    localparam logic [1:0] ST_ACTIVE = 2'b10;
    localparam logic [1:0] ST_FP     = 2'b11;

    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;

    // The encoding is chosen so that the segment cycle is a plain 2-bit increment.
    function automatic logic [1:0] next_seg(input logic [1:0] s);
        return s + 2'b01;
    endfunction

endpackage

// File: rtl/svga_timing_seq_seg_counter.sv
// One raster axis: a SYNC/BP/ACTIVE/FP state machine driven by a down-counter
// that reloads (segment length - 1) on every state entry.
module svga_seg_counter #(
    parameter int W = svga_timing_pkg::CW
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            adv,
    input  logic [3:0][W:0] lengths,
    output logic [1:0]      state,
    output logic            tc
);
    import svga_timing_pkg::*;

    logic [3:0][W-1:0] load_val;
    logic [1:0]        state_q, state_d;
    logic [W-1:0]      cnt_q, cnt_d;

    // Lengths may equal 2^W, so they arrive one bit wider; length-1 always fits W bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_load
        assign load_val[gi] = W'(lengths[gi] - (W+1)'(1));
    end

    assign tc    = (cnt_q == '0);
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (adv) begin
            if (tc) begin
                state_d = next_seg(state_q);
                cnt_d   = load_val[state_d];
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= load_val[ST_SYNC];
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/svga_timing_seq.sv
// SVGA raster timing sequencer: horizontal and vertical segment machines plus
// active-area coordinate counters and sync/blank/strobe decode.
module svga_timing_seq #(
    parameter int H_SYNC   = svga_timing_pkg::DEF_H_SYNC,
    parameter int H_BP     = svga_timing_pkg::DEF_H_BP,
    parameter int H_ACTIVE = svga_timing_pkg::DEF_H_ACTIVE,
    parameter int H_FP     = svga_timing_pkg::DEF_H_FP,
    parameter int V_SYNC   = svga_timing_pkg::DEF_V_SYNC,
    parameter int V_BP     = svga_timing_pkg::DEF_V_BP,
    parameter int V_ACTIVE = svga_timing_pkg::DEF_V_ACTIVE,
    parameter int V_FP     = svga_timing_pkg::DEF_V_FP,
    parameter int CW       = svga_timing_pkg::CW
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          end_line,
    output logic          end_frame,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y
);
    import svga_timing_pkg::*;

    localparam int LW = CW + 1;

    logic [3:0][CW:0] h_len, v_len;
    logic [1:0]       h_state, v_state;
    logic             h_tc, v_tc;
    logic [CW-1:0]    px_q, px_d, py_q, py_d;

    assign h_len[ST_SYNC]   = LW'(H_SYNC);
    assign h_len[ST_BP]     = LW'(H_BP);
    assign h_len[ST_ACTIVE] = LW'(H_ACTIVE);
    assign h_len[ST_FP]     = LW'(H_FP);
    assign v_len[ST_SYNC]   = LW'(V_SYNC);
    assign v_len[ST_BP]     = LW'(V_BP);
    assign v_len[ST_ACTIVE] = LW'(V_ACTIVE);
    assign v_len[ST_FP]     = LW'(V_FP);

    svga_seg_counter #(.W(CW)) u_h_seg (
        .sys_clk (sys_clk),
        .reset   (reset),
        .adv     (pix_en),
        .lengths (h_len),
        .state   (h_state),
        .tc      (h_tc)
    );

    // V advances on the same edge as the H FP->SYNC wrap, so each new line
    // already starts in its new vertical segment.
    svga_seg_counter #(.W(CW)) u_v_seg (
        .sys_clk (sys_clk),
        .reset   (reset),
        .adv     (end_line),
        .lengths (v_len),
        .state   (v_state),
        .tc      (v_tc)
    );

    assign end_line  = pix_en && h_tc && (h_state == ST_FP);
    assign end_frame = end_line && v_tc && (v_state == ST_FP);

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (pix_en) begin
            if (h_tc && h_state == ST_BP) begin
                px_d = '0;
            end else if (h_state == ST_ACTIVE) begin
                px_d = px_q + CW'(1);
            end
        end
        if (end_line) begin
            if (v_tc && v_state == ST_BP) begin
                py_d = '0;
            end else if (v_state == ST_ACTIVE) begin
                py_d = py_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    // Coordinate registers run one past the last pixel on exit; the mask hides that.
    assign hsync   = (h_state != ST_SYNC);
    assign vsync   = (v_state != ST_SYNC);
    assign blank_n = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
    assign pixel_x = (h_state == ST_ACTIVE) ? px_q : '0;
    assign pixel_y = (v_state == ST_ACTIVE) ? py_q : '0;

endmodule

// File: tb/tb_svga_timing_seq.sv
// Directed bench: a tiny-timing instance (H=2/3/4/1, V=1/1/2/1, 10-tick lines,
// 50-tick frames) checked every cycle, plus a default 800x600 instance.
module tb_svga_timing_seq;

    logic        clk = 1'b0;
    logic        rst, pe;
    logic        hs, vs, bn, el, ef;
    logic [10:0] px, py;

    logic        rst_d, pe_d;
    logic        hs_d, vs_d, bn_d, el_d, ef_d;
    logic [10:0] px_d, py_d;

    int n_err    = 0;
    int n_checks = 0;
    int cur_t    = 0;

    always #5 clk = ~clk;

    svga_timing_seq #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
    ) dut (
        .sys_clk(clk), .reset(rst), .pix_en(pe),
        .hsync(hs), .vsync(vs), .blank_n(bn),
        .end_line(el), .end_frame(ef),
        .pixel_x(px), .pixel_y(py)
    );

    svga_timing_seq dut_def (
        .sys_clk(clk), .reset(rst_d), .pix_en(pe_d),
        .hsync(hs_d), .vsync(vs_d), .blank_n(bn_d),
        .end_line(el_d), .end_frame(ef_d),
        .pixel_x(px_d), .pixel_y(py_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        logic [31:0] ev;
        ev = exp;
        n_checks++;
        assert (obs === ev) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, cur_t, obs, ev);
        end
    endtask

    // Expected outputs of the small instance at raster tick t with the given pix_en.
    task automatic check_all(input int t, input logic en);
        int  f, hp, ln;
        bit  hact, vact;
        f    = t % 50;
        hp   = f % 10;
        ln   = f / 10;
        hact = (hp >= 5) && (hp <= 8);
        vact = (ln == 2) || (ln == 3);
        cur_t = t;
        chk("hsync",     32'(hs), (hp >= 2) ? 1 : 0);
        chk("vsync",     32'(vs), (ln >= 1) ? 1 : 0);
        chk("blank_n",   32'(bn), (hact && vact) ? 1 : 0);
        chk("pixel_x",   32'(px), hact ? hp - 5 : 0);
        chk("pixel_y",   32'(py), vact ? ln - 2 : 0);
        chk("end_line",  32'(el), (en && hp == 9) ? 1 : 0);
        chk("end_frame", 32'(ef), (en && f == 49) ? 1 : 0);
    endtask

    initial begin
        int t;
        int hs_low, bn_high, el_cnt, el_first;
        int c_el_first, c_hs_low, c_vs_rise, c_bn_first, c_bn_cnt, c_el_cnt;
        int px_last, py_last;

        rst = 1'b1; pe = 1'b1;
        rst_d = 1'b1; pe_d = 1'b0;

        // Reset held for three edges with pix_en high.
        for (int i = 0; i < 3; i++) begin
            step();
            cur_t = -1;
            chk("rst_hsync", 32'(hs), 0);
            chk("rst_vsync", 32'(vs), 0);
            chk("rst_blank_n", 32'(bn), 0);
            chk("rst_end_line", 32'(el), 0);
            chk("rst_end_frame", 32'(ef), 0);
            chk("rst_pixel_x", 32'(px), 0);
            chk("rst_pixel_y", 32'(py), 0);
        end
        rst = 1'b0;
        $display("phase reset done");

        // Free-running: line and frame timing, one check set per tick.
        hs_low = 0; bn_high = 0; el_cnt = 0; el_first = -1;
        for (t = 0; t < 60; t++) begin
            #1;
            check_all(t, 1'b1);
            if (t < 10 && hs == 1'b0) hs_low++;
            if (t < 50 && bn == 1'b1) bn_high++;
            if (t < 50 && el == 1'b1) begin
                el_cnt++;
                if (el_first < 0) el_first = t;
            end
            step();
        end
        cur_t = t;
        chk("hsync_low_ticks", 32'(hs_low), 2);
        chk("blank_high_per_frame", 32'(bn_high), 8);
        chk("end_line_per_frame", 32'(el_cnt), 5);
        chk("first_end_line_tick", 32'(el_first), 9);
        $display("phase free-run done at tick %0d", t);

        // pix_en stall: alternate 1,0 for two lines' worth of ticks.
        hs_low = 0; el_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            pe = (k % 2 == 0);
            #1;
            check_all(t, pe);
            if (k < 20 && hs == 1'b0) hs_low++;
            if (el == 1'b1) el_cnt++;
            if (pe) t++;
            step();
        end
        pe = 1'b1;
        cur_t = t;
        chk("stall_hsync_low_cycles", 32'(hs_low), 4);
        chk("stall_end_line_cycles", 32'(el_cnt), 2);
        $display("phase stall done at tick %0d", t);

        // Run to tick 85 (H ACTIVE on V ACTIVE row 1) and reset there.
        for (; t < 85; t++) begin
            #1;
            check_all(t, 1'b1);
            step();
        end
        rst = 1'b1;
        #1;
        check_all(t, 1'b1);
        step();
        rst = 1'b0;
        cur_t = 0;
        chk("midrst_pixel_x", 32'(px), 0);
        chk("midrst_pixel_y", 32'(py), 0);
        chk("midrst_hsync", 32'(hs), 0);
        chk("midrst_vsync", 32'(vs), 0);
        for (t = 0; t < 51; t++) begin
            #1;
            check_all(t, 1'b1);
            step();
        end
        $display("phase mid-frame reset done");

        // Default 800x600 instance.
        pe_d = 1'b1;
        step();
        step();
        rst_d = 1'b0;
        c_el_first = -1; c_hs_low = 0; c_vs_rise = -1; c_bn_first = -1;
        c_bn_cnt = 0; c_el_cnt = 0; px_last = -1; py_last = -1;
        for (int c = 0; c < 29800; c++) begin
            if (el_d && c_el_first < 0) c_el_first = c;
            if (el_d && c < 29784) c_el_cnt++;
            if (c < 1056 && !hs_d) c_hs_low++;
            if (vs_d && c_vs_rise < 0) c_vs_rise = c;
            if (bn_d && c_bn_first < 0) begin
                c_bn_first = c;
                cur_t = c;
                chk("def_first_pixel_x", 32'(px_d), 0);
                chk("def_first_pixel_y", 32'(py_d), 0);
            end
            if (bn_d && c < 29784) c_bn_cnt++;
            if (c == 28728 + 799) begin
                px_last = int'(px_d);
                py_last = int'(py_d);
            end
            step();
        end
        cur_t = -1;
        chk("def_first_end_line", 32'(c_el_first), 1055);
        chk("def_hsync_low", 32'(c_hs_low), 128);
        chk("def_vsync_rise", 32'(c_vs_rise), 4224);
        chk("def_first_blank_high", 32'(c_bn_first), 28728);
        chk("def_blank_high_one_line", 32'(c_bn_cnt), 800);
        chk("def_end_line_count", 32'(c_el_cnt), 28);
        chk("def_last_pixel_x", 32'(px_last), 799);
        chk("def_last_pixel_y", 32'(py_last), 0);
        $display("phase default timing done");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
